// File: rtl/ramb4_s16_arb.sv
// Two-client round-robin front end for a single-port 256x16 block RAM.
// It also runs a full-array clear sweep after reset or when CLR is requested.
module ramb4_s16_arb #(
    parameter logic [15:0] CLR_VAL    = 16'h0000,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR,
    output logic        BUSY,
    input  logic        REQA,
    input  logic        REQB,
    input  logic        WEA,
    input  logic        WEB,
    input  logic [7:0]  ADDRA,
    input  logic [7:0]  ADDRB,
    input  logic [15:0] DIA,
    input  logic [15:0] DIB,
    output logic        GNTA,
    output logic        GNTB,
    output logic        VLDA,
    output logic        VLDB,
    output logic [15:0] DOA,
    output logic [15:0] DOB,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic [7:0]  RAM_ADDR,
    output logic [15:0] RAM_DI,
    input  logic [15:0] RAM_DO,
    output logic        RAM_RST
);
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  ca_reg, ca_next;
    logic        pri_reg, pri_next;

    logic        cl_req  [2];
    logic        cl_we   [2];
    logic [7:0]  cl_addr [2];
    logic [15:0] cl_di   [2];
    logic        gnt     [2];
    logic        vld_reg [2];
    logic        vld_next[2];
    logic        sel;

    assign cl_req[0]  = REQA;
    assign cl_req[1]  = REQB;
    assign cl_we[0]   = WEA;
    assign cl_we[1]   = WEB;
    assign cl_addr[0] = ADDRA;
    assign cl_addr[1] = ADDRB;
    assign cl_di[0]   = DIA;
    assign cl_di[1]   = DIB;

    always_comb begin
        state_next  = state_reg;
        ca_next     = ca_reg;
        pri_next    = pri_reg;
        gnt[0]      = 1'b0;
        gnt[1]      = 1'b0;
        vld_next[0] = 1'b0;
        vld_next[1] = 1'b0;
        sel         = 1'b0;
        BUSY        = 1'b0;
        RAM_EN      = 1'b0;
        RAM_WE      = 1'b0;
        RAM_ADDR    = 8'h00;
        RAM_DI      = 16'h0000;
        if (!RST) begin
            case (state_reg)
                ST_CLEAR: begin
                    BUSY     = 1'b1;
                    RAM_EN   = 1'b1;
                    RAM_WE   = 1'b1;
                    RAM_ADDR = ca_reg;
                    RAM_DI   = CLR_VAL;
                    ca_next  = ca_reg + 8'd1;
                    if (ca_reg == 8'hFF)
                        state_next = ST_RUN;
                end
                default: begin
                    if (CLR) begin
                        // clear wins over any request presented this cycle
                        state_next = ST_CLEAR;
                        ca_next    = 8'h00;
                    end else begin
                        gnt[0] = cl_req[0] && (!cl_req[1] || !pri_reg);
                        gnt[1] = cl_req[1] && (!cl_req[0] || pri_reg);
                        sel    = gnt[1];
                        if (gnt[0] || gnt[1]) begin
                            RAM_EN        = 1'b1;
                            RAM_WE        = cl_we[sel];
                            RAM_ADDR      = cl_addr[sel];
                            RAM_DI        = cl_di[sel];
                            vld_next[sel] = !cl_we[sel];
                            pri_next      = !sel;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= CLR_ON_RST ? ST_CLEAR : ST_RUN;
            ca_reg    <= 8'h00;
            pri_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ca_reg    <= ca_next;
            pri_reg   <= pri_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vld
            always_ff @(posedge CLK) begin
                if (RST)
                    vld_reg[gi] <= 1'b0;
                else
                    vld_reg[gi] <= vld_next[gi];
            end
        end
    endgenerate

    // a read granted just before reset is dropped rather than reported
    assign VLDA    = vld_reg[0] && !RST;
    assign VLDB    = vld_reg[1] && !RST;
    assign GNTA    = gnt[0];
    assign GNTB    = gnt[1];
    assign DOA     = RAM_DO;
    assign DOB     = RAM_DO;
    assign RAM_RST = 1'b0;
endmodule

// File: tb/tb_ramb4_s16_arb.sv
// Randomized and directed bench for ramb4_s16_arb with a queue-based read scoreboard.
module tb_ramb4_s16_arb;
    localparam logic [15:0] CV = 16'hA5A5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1, CLR = 1'b0;
    logic        REQA = 1'b0, REQB = 1'b0, WEA = 1'b0, WEB = 1'b0;
    logic [7:0]  ADDRA = 8'h00, ADDRB = 8'h00;
    logic [15:0] DIA = 16'h0000, DIB = 16'h0000;
    logic        BUSY, GNTA, GNTB, VLDA, VLDB, RAM_EN, RAM_WE, RAM_RST;
    logic [15:0] DOA, DOB, RAM_DI;
    logic [15:0] RAM_DO = 16'h0000;
    logic [7:0]  RAM_ADDR;

    always #5 CLK = ~CLK;

    ramb4_s16_arb #(.CLR_VAL(CV), .CLR_ON_RST(1'b1)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
        .REQA(REQA), .REQB(REQB), .WEA(WEA), .WEB(WEB),
        .ADDRA(ADDRA), .ADDRB(ADDRB), .DIA(DIA), .DIB(DIB),
        .GNTA(GNTA), .GNTB(GNTB), .VLDA(VLDA), .VLDB(VLDB),
        .DOA(DOA), .DOB(DOB),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO), .RAM_RST(RAM_RST)
    );

    // bench-side block RAM: one-cycle read latency, write-first
    logic [15:0] ram_mem [256];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) begin
                ram_mem[RAM_ADDR] <= RAM_DI;
                RAM_DO            <= RAM_DI;
            end else begin
                RAM_DO <= ram_mem[RAM_ADDR];
            end
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        int          t;
        logic [15:0] d;
    } rd_t;
    rd_t qa[$];
    rd_t qb[$];

    // reference model state
    logic [15:0] ref_mem [256];
    int          sweep_left = 0;
    int          sweep_idx  = 0;
    bit          pref_b     = 1'b0;

    // stimulus controls and per-client pending requests
    bit          rst_v = 1'b1, clr_v = 1'b0, rand_mode = 1'b0;
    bit          keep_rd [2];
    bit          p_act   [2];
    bit          p_we    [2];
    logic [7:0]  p_addr  [2];
    logic [15:0] p_di    [2];

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    endfunction

    task automatic set_req(int c, bit we, logic [7:0] a, logic [15:0] d);
        p_act[c]  = 1'b1;
        p_we[c]   = we;
        p_addr[c] = a;
        p_di[c]   = d;
    endtask

    task automatic tick();
        int   w;
        logic e_busy, e_a, e_b, e_en, e_we;
        logic [7:0]  e_addr;
        logic [15:0] e_di;
        rd_t  ent;
        for (int c = 0; c < 2; c++) begin
            if (!p_act[c]) begin
                if (keep_rd[c])
                    set_req(c, 1'b0, 8'($urandom_range(0, 255)), 16'h0000);
                else if (rand_mode && $urandom_range(0, 2) != 0)
                    set_req(c, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                            16'($urandom));
            end
        end
        @(posedge CLK);
        #1;
        RST = rst_v;  CLR = clr_v;
        REQA = p_act[0]; WEA = p_we[0]; ADDRA = p_addr[0]; DIA = p_di[0];
        REQB = p_act[1]; WEB = p_we[1]; ADDRB = p_addr[1]; DIB = p_di[1];
        @(negedge CLK);
        w = -1;
        e_busy = 1'b0; e_a = 1'b0; e_b = 1'b0; e_en = 1'b0; e_we = 1'b0;
        e_addr = 8'h00; e_di = 16'h0000;
        if (rst_v) begin
            chk("rst_outputs", {BUSY, GNTA, GNTB, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, RAM_RST}, 64'd0);
            sweep_left = 256;
            sweep_idx  = 0;
            pref_b     = 1'b0;
        end else begin
            if (sweep_left > 0) begin
                e_busy = 1'b1; e_en = 1'b1; e_we = 1'b1;
                e_addr = 8'(sweep_idx); e_di = CV;
                ref_mem[sweep_idx] = CV;
                sweep_idx++;
                sweep_left--;
            end else if (clr_v) begin
                sweep_left = 256;
                sweep_idx  = 0;
            end else begin
                if (p_act[0] && p_act[1]) w = pref_b ? 1 : 0;
                else if (p_act[0])        w = 0;
                else if (p_act[1])        w = 1;
                if (w >= 0) begin
                    e_en = 1'b1; e_we = p_we[w]; e_addr = p_addr[w]; e_di = p_di[w];
                    e_a = (w == 0); e_b = (w == 1);
                    if (p_we[w]) begin
                        ref_mem[p_addr[w]] = p_di[w];
                    end else begin
                        ent.t = cyc + 1;
                        ent.d = ref_mem[p_addr[w]];
                        if (w == 0) qa.push_back(ent);
                        else        qb.push_back(ent);
                    end
                    pref_b   = (w == 0);
                    p_act[w] = 1'b0;
                end
            end
            chk("ctrl", {BUSY, GNTA, GNTB, RAM_EN, RAM_RST}, {e_busy, e_a, e_b, e_en, 1'b0});
            if (e_en)
                chk("ram_port", {RAM_WE, RAM_ADDR, RAM_DI}, {e_we, e_addr, e_di});
        end
    endtask

    // scoreboard monitor: one expected read per VLD, stamped with its cycle
    task automatic mon(int c, logic vld, logic [15:0] dout);
        int  sz;
        bit  due;
        rd_t f;
        sz = (c == 0) ? qa.size() : qb.size();
        f  = '0;
        if (sz > 0) f = (c == 0) ? qa[0] : qb[0];
        if (sz > 0 && f.t < cyc) begin
            chk((c == 0) ? "stale_a" : "stale_b", 64'(f.t), 64'(cyc));
            if (c == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            sz = sz - 1;
            if (sz > 0) f = (c == 0) ? qa[0] : qb[0];
        end
        due = (sz > 0) && (f.t == cyc);
        if (RST) begin
            chk((c == 0) ? "vlda_rst" : "vldb_rst", 64'(vld), 64'd0);
            if (due) begin
                if (c == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end else begin
            chk((c == 0) ? "vlda" : "vldb", 64'(vld), 64'(due));
            if (due) begin
                chk((c == 0) ? "doa" : "dob", 64'(dout), 64'(f.d));
                if (c == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            mon(0, VLDA, DOA);
            mon(1, VLDB, DOB);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'hDEAD;
            ref_mem[i] = 16'hDEAD;
        end
        for (int c = 0; c < 2; c++) begin
            keep_rd[c] = 1'b0; p_act[c] = 1'b0; p_we[c] = 1'b0;
            p_addr[c] = 8'h00; p_di[c] = 16'h0000;
        end

        // reset sweep, then read back three addresses
        rst_v = 1'b1; tick(); tick(); rst_v = 1'b0;
        repeat (256) tick();
        set_req(0, 1'b0, 8'd0, 16'h0);   tick();
        set_req(0, 1'b0, 8'd128, 16'h0); tick();
        set_req(0, 1'b0, 8'd255, 16'h0); tick();

        // single-client write then read-after-write
        set_req(0, 1'b1, 8'h10, 16'h1234); tick();
        set_req(0, 1'b0, 8'h10, 16'h0);    tick();
        tick();

        // contention right after a reset sweep
        rst_v = 1'b1; tick(); tick(); rst_v = 1'b0;
        repeat (256) tick();
        keep_rd[0] = 1'b1; keep_rd[1] = 1'b1;
        repeat (6) tick();
        keep_rd[0] = 1'b0; keep_rd[1] = 1'b0;
        repeat (3) tick();

        // priority memory: lone B grant then simultaneous requests
        set_req(1, 1'b0, 8'd5, 16'h0); tick();
        set_req(0, 1'b0, 8'd6, 16'h0);
        set_req(1, 1'b0, 8'd7, 16'h0);
        repeat (3) tick();

        // clear beats a same-cycle request; a mid-sweep pulse is ignored
        set_req(0, 1'b0, 8'd3, 16'h0);
        clr_v = 1'b1; tick(); clr_v = 1'b0;
        repeat (100) tick();
        clr_v = 1'b1; tick(); clr_v = 1'b0;
        repeat (160) tick();

        // reset while the sweep is at address 100
        clr_v = 1'b1; tick(); clr_v = 1'b0;
        for (int k = 0; k < 300 && sweep_idx < 100; k++) tick();
        chk("sweep_reach_100", 64'(sweep_idx), 64'd100);
        rst_v = 1'b1; tick(); rst_v = 1'b0;
        repeat (260) tick();

        // randomized traffic with rare clears and resets
        rand_mode = 1'b1;
        repeat (3000) begin
            clr_v = ($urandom_range(0, 499) == 0);
            rst_v = ($urandom_range(0, 999) == 0);
            tick();
        end
        rand_mode = 1'b0; clr_v = 1'b0; rst_v = 1'b0;
        repeat (300) tick();
        chk("queues_drained", 64'(qa.size() + qb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
